// File: rtl/wb_stage.sv
// Writeback stage: load-response wait/hold, load alignment and extension,
// register-file write port, 64-bit instret. Optional trace port: WB_RVFI_EN.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_func_out,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_regf_we,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        wb_stall,
  output logic        regf_we,
  output logic [4:0]  regf_rd_addr,
  output logic [31:0] regf_wdata,
  output logic [63:0] instret,
  output logic        rvfi_valid,
  output logic [63:0] rvfi_order,
  output logic [31:0] rvfi_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HELD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [63:0] instret_q;
  logic        commit;
  logic        is_load;
  logic [31:0] word_w;
  logic [1:0]  off;
  logic [7:0]  byte_w;
  logic [15:0] half_w;
  logic [31:0] load_val;

  assign is_load = mem_valid & mem_read;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // next state; a response under stall is parked in hold_q
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_load && !dmem_resp) begin
          state_d = S_WAIT;
        end else if (is_load && stall_in) begin
          state_d = S_HELD;
          hold_d  = dmem_rdata;
        end
      end
      S_WAIT: begin
        if (dmem_resp) begin
          if (stall_in) begin
            state_d = S_HELD;
            hold_d  = dmem_rdata;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HELD: begin
        if (!stall_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    wb_stall = is_load & ~(dmem_resp | (state_q == S_HELD));
    commit   = mem_valid & ~stall_in & ~wb_stall;
    regf_we  = commit & mem_regf_we & (mem_rd_addr != 5'd0);
    word_w   = dmem_resp ? dmem_rdata : hold_q;
    off      = mem_func_out[1:0];
    byte_w   = word_w[{off, 3'b000} +: 8];
    half_w   = word_w[{off[1], 4'b0000} +: 16];
    case (mem_funct3)
      3'b000:  load_val = {{24{byte_w[7]}}, byte_w};
      3'b001:  load_val = {{16{half_w[15]}}, half_w};
      3'b010:  load_val = word_w;
      3'b100:  load_val = {24'd0, byte_w};
      3'b101:  load_val = {16'd0, half_w};
      default: load_val = 'x;
    endcase
    regf_wdata   = mem_read ? load_val : mem_func_out;
    regf_rd_addr = mem_rd_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (commit) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;

`ifdef WB_RVFI_EN
  logic [63:0] order_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      order_q <= '0;
    else if (commit) order_q <= order_q + 64'd1;
  end

  assign rvfi_valid     = commit;
  assign rvfi_order     = order_q;
  assign rvfi_mem_rdata = is_load ? word_w : 32'd0;
`else
  assign rvfi_valid     = 1'b0;
  assign rvfi_order     = 64'd0;
  assign rvfi_mem_rdata = 32'd0;
`endif

`ifndef SYNTHESIS
  // a second response while data is parked would be lost
  a_no_resp_held: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(state_q == S_HELD && dmem_resp));
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed cases with literal expectations plus
// randomized load/ALU traffic against a behavioural model.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        mem_valid;
  logic        mem_read;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_func_out;
  logic [4:0]  mem_rd_addr;
  logic        mem_regf_we;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        wb_stall;
  logic        regf_we;
  logic [4:0]  regf_rd_addr;
  logic [31:0] regf_wdata;
  logic [63:0] instret;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_in       (stall_in),
    .mem_valid      (mem_valid),
    .mem_read       (mem_read),
    .mem_funct3     (mem_funct3),
    .mem_func_out   (mem_func_out),
    .mem_rd_addr    (mem_rd_addr),
    .mem_regf_we    (mem_regf_we),
    .dmem_resp      (dmem_resp),
    .dmem_rdata     (dmem_rdata),
    .wb_stall       (wb_stall),
    .regf_we        (regf_we),
    .regf_rd_addr   (regf_rd_addr),
    .regf_wdata     (regf_wdata),
    .instret        (instret),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_mem_rdata (rvfi_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_held;
  logic [31:0] m_word;
  longint unsigned m_instret;
  longint unsigned m_order;

  function automatic logic [31:0] ext(input logic [2:0] f3,
                                      input logic [31:0] w,
                                      input logic [1:0] a);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  logic        e_stall;
  logic        e_commit;
  logic        e_we;
  logic [31:0] e_word;
  logic [31:0] e_wdata;
  logic        w_known;

  always_comb begin
    e_stall  = mem_valid && mem_read && !(dmem_resp || m_held);
    e_commit = mem_valid && !stall_in && !e_stall;
    e_we     = e_commit && mem_regf_we && (mem_rd_addr != 0);
    e_word   = dmem_resp ? dmem_rdata : m_word;
    e_wdata  = mem_read ? ext(mem_funct3, e_word, mem_func_out[1:0])
                        : mem_func_out;
    w_known  = dmem_resp || m_held;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_held    <= 0;
      m_word    <= 0;
      m_instret <= 0;
      m_order   <= 0;
    end else begin
      if (e_commit) begin
        m_instret <= m_instret + 1;
        m_order   <= m_order + 1;
      end
      if (m_held && !stall_in) m_held <= 0;
      else if (!m_held && mem_valid && mem_read && dmem_resp && stall_in) begin
        m_held <= 1;
        m_word <= dmem_rdata;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one compare process, mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_wb_stall", {63'd0, wb_stall}, {63'd0, e_stall});
      chk("m_regf_we", {63'd0, regf_we}, {63'd0, e_we});
      chk("m_rd_addr", {59'd0, regf_rd_addr}, {59'd0, mem_rd_addr});
      chk("m_instret", instret, m_instret);
      if (mem_valid && (!mem_read || w_known))
        chk("m_wdata", {32'd0, regf_wdata}, {32'd0, e_wdata});
`ifdef WB_RVFI_EN
      chk("m_rvfi_valid", {63'd0, rvfi_valid}, {63'd0, e_commit});
      chk("m_rvfi_order", rvfi_order, m_order);
      if (!(mem_valid && mem_read))
        chk("m_rvfi_rdata", {32'd0, rvfi_mem_rdata}, 64'd0);
      else if (w_known)
        chk("m_rvfi_rdata", {32'd0, rvfi_mem_rdata}, {32'd0, e_word});
`else
      chk("m_rvfi_valid", {63'd0, rvfi_valid}, 64'd0);
      chk("m_rvfi_order", rvfi_order, 64'd0);
      chk("m_rvfi_rdata", {32'd0, rvfi_mem_rdata}, 64'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic r, input logic [2:0] f3,
                     input logic [31:0] a, input logic [4:0] rd,
                     input logic we, input logic st, input logic rs,
                     input logic [31:0] rdat);
    mem_valid    = v;
    mem_read     = r;
    mem_funct3   = f3;
    mem_func_out = a;
    mem_rd_addr  = rd;
    mem_regf_we  = we;
    stall_in     = st;
    dmem_resp    = rs;
    dmem_rdata   = rdat;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3s [5];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    smp();
    chk("rst_wb_stall", {63'd0, wb_stall}, 64'd0);
    chk("rst_regf_we", {63'd0, regf_we}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_rvfi_valid", {63'd0, rvfi_valid}, 64'd0);
    tick();
    rst_n = 1'b1;

    // ALU op
    drv(1, 0, 0, 32'h1234, 5'd5, 1, 0, 0, 0);
    smp();
    chk("alu_we", {63'd0, regf_we}, 64'd1);
    chk("alu_wdata", {32'd0, regf_wdata}, 64'h1234);
    chk("alu_instret0", instret, 64'd0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    smp();
    chk("alu_instret1", instret, 64'd1);
    tick();

    // lb, zero-latency response
    drv(1, 1, 3'd0, 32'h1000_0003, 5'd7, 1, 0, 1, 32'h80FF_0000);
    smp();
    chk("lb_stall", {63'd0, wb_stall}, 64'd0);
    chk("lb_wdata", {32'd0, regf_wdata}, 64'hFFFF_FF80);
    tick();

    // lhu, response three cycles late
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 3'd5, 32'h2000_0002, 5'd8, 1, 0, 0, 32'h5555_5555);
      smp();
      chk("lhu_stall", {63'd0, wb_stall}, 64'd1);
      tick();
    end
    drv(1, 1, 3'd5, 32'h2000_0002, 5'd8, 1, 0, 1, 32'hBEEF_0001);
    smp();
    chk("lhu_stall_end", {63'd0, wb_stall}, 64'd0);
    chk("lhu_we", {63'd0, regf_we}, 64'd1);
    chk("lhu_wdata", {32'd0, regf_wdata}, 64'h0000_BEEF);
    tick();

    // lw, response under stall, held for 2 cycles
    drv(1, 1, 3'd2, 32'h3000_0000, 5'd9, 1, 1, 1, 32'hDEAD_BEEF);
    smp();
    chk("lw_held_stall0", {63'd0, wb_stall}, 64'd0);
    chk("lw_held_we0", {63'd0, regf_we}, 64'd0);
    tick();
    drv(1, 1, 3'd2, 32'h3000_0000, 5'd9, 1, 1, 0, 32'h1111_1111);
    smp();
    chk("lw_held_stall1", {63'd0, wb_stall}, 64'd0);
    chk("lw_held_we1", {63'd0, regf_we}, 64'd0);
    tick();
    drv(1, 1, 3'd2, 32'h3000_0000, 5'd9, 1, 0, 0, 32'h2222_2222);
    smp();
    chk("lw_rel_we", {63'd0, regf_we}, 64'd1);
    chk("lw_rel_wdata", {32'd0, regf_wdata}, 64'hDEAD_BEEF);
    tick();

    // write to x0
    drv(1, 0, 0, 32'hCAFE, 5'd0, 1, 0, 0, 0);
    smp();
    chk("x0_we", {63'd0, regf_we}, 64'd0);
    chk("x0_instret", instret, 64'd4);
`ifdef WB_RVFI_EN
    chk("x0_rvfi_valid", {63'd0, rvfi_valid}, 64'd1);
    chk("x0_rvfi_order", rvfi_order, 64'd4);
`endif
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    smp();
    chk("x0_instret_after", instret, 64'd5);
`ifdef WB_RVFI_EN
    chk("x0_rvfi_order_after", rvfi_order, 64'd5);
`endif
    tick();

    // reset while waiting for a load
    drv(1, 1, 3'd2, 32'h4000_0000, 5'd10, 1, 0, 0, 0);
    tick();
    tick();
    #2;
    mem_valid = 0;
    rst_n = 0;
    #1;
    chk("rstw_instret", instret, 64'd0);
    tick();
    rst_n = 1;
    drv(0, 0, 0, 0, 5'd10, 1, 0, 1, 32'h7777_7777);
    smp();
    chk("rstw_we", {63'd0, regf_we}, 64'd0);
    chk("rstw_instret2", instret, 64'd0);
    tick();
    drv(1, 1, 3'd2, 32'h4000_0000, 5'd10, 1, 0, 0, 0);
    smp();
    chk("rstw_new_stall", {63'd0, wb_stall}, 64'd1);
    tick();
    drv(1, 1, 3'd2, 32'h4000_0000, 5'd10, 1, 0, 1, 32'h0BAD_F00D);
    smp();
    chk("rstw_new_wdata", {32'd0, regf_wdata}, 64'h0BAD_F00D);
    tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit          ld;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [4:0]  rd;
      bit          we;
      int          d;
      int          cyc;
      bit          done;
      int          gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drv(0, 1'($urandom), 3'($urandom), $urandom, 5'($urandom),
            1'($urandom), 1'($urandom), 0, $urandom);
        tick();
      end
      ld   = ($urandom % 2) == 0;
      f3   = ld ? f3s[$urandom_range(0, 4)] : 3'($urandom);
      a    = $urandom;
      rd   = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      we   = ($urandom % 5) != 0;
      d    = $urandom_range(0, 3);
      cyc  = 0;
      done = 0;
      while (!done) begin
        drv(1, ld, f3, a, rd, we, ($urandom % 4) == 0,
            ld && (cyc == d), $urandom);
        smp();
        done = e_commit;
        tick();
        cyc++;
        if (cyc > 60) begin
          chk("rand_timeout", 64'd0, 64'd1);
          done = 1;
        end
      end
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback pipeline stage of the rv32imc core, directly downstream of the data-memory stage. Consumes the registered memory-stage outputs and the data-memory read response, waits for outstanding load data, aligns and sign/zero-extends loads, and drives the register-file write port. It also raises the stall request that freezes the pipeline while a load response is pending, and keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- stall_in  in  1  stall from other sources (fetch miss, etc.); WB must not commit while high
- mem_valid  in  1  WB slot holds a real instruction
- mem_read  in  1  instruction is a load
- mem_funct3  in  3  load type: lb 000, lh 001, lw 010, lbu 100, lhu 101
- mem_func_out  in  32  ALU result / load address
- mem_rd_addr  in  5  destination register
- mem_regf_we  in  1  instruction writes rd
- dmem_resp  in  1  data memory read data valid this cycle
- dmem_rdata  in  32  word-aligned read data, valid only with dmem_resp
- wb_stall  out  1  load data not yet available; freeze pipeline
- regf_we  out  1  register-file write strobe
- regf_rd_addr  out  5  write address
- regf_wdata  out  32  write data
- instret  out  64  retired-instruction count
- rvfi_valid  out  1  commit strobe for formal/trace monitor
- rvfi_order  out  64  commit order of the retiring instruction
- rvfi_mem_rdata  out  32  raw load word for the retiring load

## Operation
- State machine, registered: IDLE, WAIT, HELD.
  - IDLE: slot empty or non-load, or load whose response arrives this cycle.
  - IDLE→WAIT: mem_valid & mem_read & !dmem_resp.
  - WAIT→IDLE: dmem_resp & !stall_in (commit in that cycle, data taken directly from dmem_rdata).
  - WAIT→HELD, or IDLE→HELD for a load: dmem_resp & stall_in. dmem_rdata is captured into hold_data.
  - HELD→IDLE: !stall_in (commit using hold_data).
- wb_stall = mem_valid & mem_read & !(dmem_resp | state==HELD). Combinational.
- commit = mem_valid & !stall_in & !wb_stall.
- regf_we = commit & mem_regf_we & (mem_rd_addr != 0).
- regf_rd_addr = mem_rd_addr.
- regf_wdata selection:
  - For loads: extended load word; otherwise mem_func_out.
  - Load word W = dmem_resp ? dmem_rdata : hold_data. Offset = mem_func_out[1:0].
  - lb/lbu: byte W[8*off +: 8], sign/zero extended.
  - lh/lhu: half W[16*off[1] +: 16], sign/zero extended; off[0] ignored (misaligned not generated upstream).
  - lw: W.
  - Any other funct3: regf_wdata = 32'hx in simulation; regf_we is still governed by the commit rule.
- instret increments by 1 on each commit; it wraps modulo 2^64.
- A second dmem_resp while in HELD is a protocol error. hold_data is not overwritten; a simulation assertion fires.

## Timing
- Reset (asynchronous, rst_n low) values: state=IDLE, hold_data=0, instret=0, rvfi_order=0. All combinational outputs follow from these with mem_valid low: wb_stall=0, regf_we=0, rvfi_valid=0.
- Zero-latency path: a load whose dmem_resp arrives in the same cycle it occupies WB commits that cycle, with wb_stall=0.
- An N-cycle response delay gives N cycles of wb_stall=1, then commit in the dmem_resp cycle if stall_in=0.
- Response arriving under stall_in: the data is held, and commit occurs in the first cycle with stall_in=0. wb_stall stays 0 while HELD.
- Reset asserted in WAIT or HELD: the pending load is dropped and no commit occurs. The instret and order counters return to 0 immediately.
- regf write data is visible to the register file at the commit clock edge. There is no added pipeline latency.

## Configuration
- WB_RVFI_EN defined:
  - rvfi_valid = commit.
  - rvfi_order is the registered count of prior commits; it increments after each commit.
  - rvfi_mem_rdata = W for loads and 0 otherwise.
- WB_RVFI_EN undefined:
  - rvfi_valid, rvfi_order and rvfi_mem_rdata are tied to 0.
  - The order counter is not synthesized.
  - instret and all datapath behaviour are unchanged.

## Test plan
- ALU op, mem_func_out=0x1234, rd=5, mem_regf_we=1, stall_in=0 -> same cycle: regf_we=1, regf_wdata=0x1234, instret 0→1.
- lb at addr 0x..03, dmem_rdata=0x80FF_0000 with dmem_resp the same cycle -> regf_wdata=0xFFFF_FF80, wb_stall=0.
- lhu at addr 0x..02, dmem_resp 3 cycles late with rdata 0xBEEF_0001 -> wb_stall=1 for 3 cycles, then regf_wdata=0x0000_BEEF.
- lw, dmem_resp=1 with rdata 0xDEAD_BEEF while stall_in=1 for 2 cycles -> state HELD, wb_stall=0, no write; commit of 0xDEAD_BEEF on the first cycle with stall_in=0.
- Write to rd=0 -> regf_we=0, instret still increments. With WB_RVFI_EN defined, rvfi_valid=1 and rvfi_order increments.
- rst_n pulsed low while in WAIT -> state IDLE, instret=0, no commit; a later dmem_resp with mem_valid=0 is ignored.
